// File: rtl/result_select_pipe.sv
// Registered N:1 result selector with a 2-entry skid buffer on a valid/ready output.
// Optional out_selerr flag for out-of-range selects: define RESULT_SELECT_SELERR_EN.
module result_select_pipe #(
    parameter int W = 64,
    parameter int N = 16,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_bus,
    input  logic [SW-1:0]  sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_zero,
    output logic           out_valid,
    input  logic           out_ready
`ifdef RESULT_SELECT_SELERR_EN
    ,
    output logic           out_selerr
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // in_ready is a flop (0 only when both entries hold data), so out_ready never
    // reaches in_ready combinationally; payload on out_* is held while stalled.

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           in_ready_q, in_ready_d;

    logic [W-1:0]   m_data_q, m_data_d;
    logic [SW-1:0]  m_sel_q, m_sel_d;
    logic           m_zero_q, m_zero_d;
    logic [W-1:0]   s_data_q, s_data_d;
    logic [SW-1:0]  s_sel_q, s_sel_d;
    logic           s_zero_q, s_zero_d;

    logic [W-1:0]   cap_data;
    logic           cap_zero;
    logic           accept;
    logic           drain;
    logic           load_m_in;
    logic           load_m_skid;
    logic           load_s;

    // Unmatched selects (only possible for non-power-of-two N) fall through to zero.
    always_comb begin
        cap_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                cap_data = in_bus[k*W +: W];
            end
        end
    end

    assign cap_zero = (cap_data == '0);

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        accept      = in_valid && in_ready_q;
        drain       = (state_q != ST_EMPTY) && out_ready;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_m_in = 1'b1;
                    state_d   = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    load_m_in = 1'b1;
                end else if (accept) begin
                    load_s  = 1'b1;
                    state_d = ST_FULL;
                end else if (drain) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    load_m_skid = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        m_data_d = m_data_q;
        m_sel_d  = m_sel_q;
        m_zero_d = m_zero_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        s_zero_d = s_zero_q;
        if (load_m_in) begin
            m_data_d = cap_data;
            m_sel_d  = sel;
            m_zero_d = cap_zero;
        end else if (load_m_skid) begin
            m_data_d = s_data_q;
            m_sel_d  = s_sel_q;
            m_zero_d = s_zero_q;
        end
        if (load_s) begin
            s_data_d = cap_data;
            s_sel_d  = sel;
            s_zero_d = cap_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_data_q   <= '0;
            m_sel_q    <= '0;
            m_zero_q   <= 1'b1;
            s_data_q   <= '0;
            s_sel_q    <= '0;
            s_zero_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_data_q   <= m_data_d;
            m_sel_q    <= m_sel_d;
            m_zero_q   <= m_zero_d;
            s_data_q   <= s_data_d;
            s_sel_q    <= s_sel_d;
            s_zero_q   <= s_zero_d;
        end
    end

`ifdef RESULT_SELECT_SELERR_EN
    logic cap_err;
    logic m_err_q, m_err_d;
    logic s_err_q, s_err_d;

    assign cap_err = ({1'b0, sel} >= (SW+1)'(N));

    // The error flag follows exactly the same load paths as its data.
    always_comb begin
        m_err_d = m_err_q;
        s_err_d = s_err_q;
        if (load_m_in) begin
            m_err_d = cap_err;
        end else if (load_m_skid) begin
            m_err_d = s_err_q;
        end
        if (load_s) begin
            s_err_d = cap_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err_q <= 1'b0;
            s_err_q <= 1'b0;
        end else begin
            m_err_q <= m_err_d;
            s_err_q <= s_err_d;
        end
    end

    assign out_selerr = m_err_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = m_data_q;
    assign out_sel   = m_sel_q;
    assign out_zero  = m_zero_q;

endmodule
